regfile_2r1w: RTL and testbench

REGFILE_2R1W -- requirements
Module: regfile_2r1w

---
 rtl/regfile_2r1w_pkg.sv | 7 +
 rtl/regfile_2r1w_reg_read_mux.sv | 14 +
 rtl/regfile_2r1w.sv | 74 +++++++
 tb/tb_regfile_2r1w.sv | 103 ++++++++++
 4 files changed

// File: rtl/regfile_2r1w_pkg.sv
// regfile_2r1w_pkg: FSM state type and address-width helper shared by the register file and its read mux
package regfile_2r1w_pkg;
  typedef enum logic {IDLE, CLEAR} state_e;
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/regfile_2r1w_reg_read_mux.sv
// reg_read_mux: DEPTH-to-1 register select; ports regs_i (flattened storage), addr_i, data_o (zero when addr_i >= DEPTH)
module reg_read_mux
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = addr_width(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] regs_i,
  input  logic [AW-1:0]               addr_i,
  output logic [WIDTH-1:0]            data_o
);
  assign data_o = ({1'b0, addr_i} < (AW+1)'(DEPTH)) ? regs_i[addr_i] : '0;
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read/1-write register file with registered reads, write-first bypass and a clear sweep; ports clk, reset, we/wAddr/wData, re0/rAddr0/rData0/rValid0, re1/rAddr1/rData1/rValid1, clr, busy
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter bit ZERO_R0 = 1'b0,
  localparam int AW = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wAddr,
  input  logic [WIDTH-1:0] wData,
  input  logic             re0,
  input  logic [AW-1:0]    rAddr0,
  output logic [WIDTH-1:0] rData0,
  output logic             rValid0,
  input  logic             re1,
  input  logic [AW-1:0]    rAddr1,
  output logic [WIDTH-1:0] rData1,
  output logic             rValid1,
  input  logic             clr,
  output logic             busy
);
  state_e                       state_q, state_d;
  logic [AW-1:0]                idx_q, idx_d;
  logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
  logic [WIDTH-1:0]             rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                         rvalid0_q, rvalid1_q;
  logic [WIDTH-1:0]             m0, m1, rd0, rd1;
  logic                         wr_ok, idx_last;
  assign busy     = (state_q == CLEAR);
  assign idx_last = (idx_q == AW'(DEPTH - 1));
  // address 0 is never accepted when hard-wired, so it is never bypassed either
  assign wr_ok = we && !busy && ({1'b0, wAddr} < (AW+1)'(DEPTH)) && !(ZERO_R0 && wAddr == '0);
  reg_read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mux0 (.regs_i(mem_q), .addr_i(rAddr0), .data_o(m0));
  reg_read_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mux1 (.regs_i(mem_q), .addr_i(rAddr1), .data_o(m1));
  // the sweep entry reads as zero the cycle it is cleared; writes and sweep never coincide
  assign rd0 = (busy && rAddr0 == idx_q) ? '0 : (wr_ok && rAddr0 == wAddr) ? wData : m0;
  assign rd1 = (busy && rAddr1 == idx_q) ? '0 : (wr_ok && rAddr1 == wAddr) ? wData : m1;
  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[wAddr] = wData;
    if (busy) mem_d[idx_q] = '0;
    state_d  = busy ? (idx_last ? IDLE : CLEAR) : (clr ? CLEAR : IDLE);
    idx_d    = (busy && !idx_last) ? idx_q + 1'b1 : '0;
    rdata0_d = re0 ? rd0 : rdata0_q;
    rdata1_d = re1 ? rd1 : rdata1_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      mem_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mem_q     <= mem_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= re0;
      rvalid1_q <= re1;
    end
  end
  assign rData0  = rdata0_q;
  assign rData1  = rdata1_q;
  assign rValid0 = rvalid0_q;
  assign rValid1 = rvalid1_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed bench over three shared-stimulus instances (default, ZERO_R0=1, DEPTH=6)
module tb_regfile_2r1w;
  logic        clk = 1'b0;
  logic        reset = 1'b1, we = 1'b0, re0 = 1'b0, re1 = 1'b0, clr = 1'b0;
  logic [2:0]  wAddr = '0, rAddr0 = '0, rAddr1 = '0;
  logic [31:0] wData = '0;
  logic [31:0] a_rd0, a_rd1, b_rd0, b_rd1, c_rd0, c_rd1;
  logic        a_rv0, a_rv1, b_rv0, b_rv1, c_rv0, c_rv1, a_busy, b_busy, c_busy;
  int          errors = 0, checks = 0;
  logic [31:0] c_exp [6];
  always #5 clk = ~clk;
  regfile_2r1w a (.clk(clk), .reset(reset), .we(we), .wAddr(wAddr), .wData(wData), .re0(re0), .rAddr0(rAddr0),
    .rData0(a_rd0), .rValid0(a_rv0), .re1(re1), .rAddr1(rAddr1), .rData1(a_rd1), .rValid1(a_rv1), .clr(clr), .busy(a_busy));
  regfile_2r1w #(.ZERO_R0(1'b1)) b (.clk(clk), .reset(reset), .we(we), .wAddr(wAddr), .wData(wData), .re0(re0), .rAddr0(rAddr0),
    .rData0(b_rd0), .rValid0(b_rv0), .re1(re1), .rAddr1(rAddr1), .rData1(b_rd1), .rValid1(b_rv1), .clr(clr), .busy(b_busy));
  regfile_2r1w #(.DEPTH(6)) c (.clk(clk), .reset(reset), .we(we), .wAddr(wAddr), .wData(wData), .re0(re0), .rAddr0(rAddr0),
    .rData0(c_rd0), .rValid0(c_rv0), .re1(re1), .rAddr1(rAddr1), .rData1(c_rd1), .rValid1(c_rv1), .clr(clr), .busy(c_busy));
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle_inputs;
    we = 1'b0; re0 = 1'b0; re1 = 1'b0; clr = 1'b0;
  endtask
  initial begin
    c_exp = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h12345678};
    tick; tick;
    chk("rst_rv0", a_rv0, 0); chk("rst_rd0", a_rd0, 0); chk("rst_busy", a_busy, 0);
    reset = 1'b0;
    we = 1; wAddr = 3; wData = 32'hDEADBEEF; tick;
    we = 0; re0 = 1; rAddr0 = 3; tick;
    chk("s1_rd0", a_rd0, 32'hDEADBEEF); chk("s1_rv0", a_rv0, 1);
    re0 = 0; tick;
    chk("s1_rv0_pulse", a_rv0, 0); chk("s1_rd0_hold", a_rd0, 32'hDEADBEEF);
    we = 1; wAddr = 5; wData = 32'h12345678; re1 = 1; rAddr1 = 5; re0 = 1; rAddr0 = 5; tick;
    chk("s2_rd1_bypass", a_rd1, 32'h12345678); chk("s2_rv1", a_rv1, 1);
    chk("s2_rd0_same", a_rd0, 32'h12345678); chk("s2_c_rd1", c_rd1, 32'h12345678);
    idle_inputs; tick;
    we = 1; wAddr = 0; wData = 32'hFFFFFFFF; re0 = 1; rAddr0 = 0; tick;
    chk("s3_b_rd0_nobyp", b_rd0, 0); chk("s3_a_rd0_byp", a_rd0, 32'hFFFFFFFF);
    we = 0; re0 = 1; re1 = 1; rAddr0 = 0; rAddr1 = 0; tick;
    chk("s3_b_rd0", b_rd0, 0); chk("s3_b_rd1", b_rd1, 0); chk("s3_a_rd1", a_rd1, 32'hFFFFFFFF);
    idle_inputs;
    re0 = 1; rAddr0 = 7; tick;
    chk("s6_oor_rd0", c_rd0, 0); chk("s6_oor_rv0", c_rv0, 1);
    re0 = 0; we = 1; wAddr = 6; wData = 32'hCAFEF00D; tick;
    we = 0;
    for (int i = 0; i < 6; i++) begin
      re0 = 1; rAddr0 = 3'(i); re1 = 1; rAddr1 = 6; tick;
      chk($sformatf("s6_rd_%0d", i), c_rd0, c_exp[i]);
      chk($sformatf("s6_rd6_%0d", i), c_rd1, 0);
    end
    idle_inputs;
    for (int i = 0; i < 8; i++) begin
      we = 1; wAddr = 3'(i); wData = 32'h11 * (i + 1); tick;
    end
    we = 0; clr = 1; tick;
    for (int k = 0; k < 8; k++) begin
      idle_inputs;
      chk($sformatf("s4_busy_%0d", k), a_busy, 1);
      if (k == 5) chk("s4_c_busy_last", c_busy, 1);
      if (k == 6) chk("s4_c_busy_done", c_busy, 0);
      if (k == 7) chk("s4_b_busy", b_busy, 1);
      if (k == 2) begin we = 1; wAddr = 0; wData = 32'hAAAA; clr = 1; end
      if (k == 3) begin re0 = 1; rAddr0 = 3; re1 = 1; rAddr1 = 6; end
      tick;
      if (k == 3) begin
        chk("s4_rd_clearing", a_rd0, 0);
        chk("s4_rd_pending", a_rd1, 32'h77);
      end
    end
    idle_inputs;
    chk("s4_busy_end", a_busy, 0);
    for (int i = 0; i < 8; i++) begin
      re0 = 1; rAddr0 = 3'(i); re1 = 1; rAddr1 = 3'(7 - i); tick;
      chk($sformatf("s4_rd0_%0d", i), a_rd0, 0);
      chk($sformatf("s4_rd1_%0d", i), a_rd1, 0);
    end
    idle_inputs;
    for (int i = 0; i < 8; i++) begin
      we = 1; wAddr = 3'(i); wData = 32'h100 + i; tick;
    end
    we = 0; clr = 1; tick;
    clr = 0; tick; tick;
    reset = 1; re0 = 1; rAddr0 = 7; we = 1; wAddr = 4; wData = 1; tick;
    reset = 0; idle_inputs;
    chk("s5_busy", a_busy, 0); chk("s5_rv0", a_rv0, 0); chk("s5_rd0", a_rd0, 0);
    we = 1; wAddr = 2; wData = 32'h99; re1 = 1; rAddr1 = 2; re0 = 1; rAddr0 = 7; tick;
    chk("s5_first_byp", a_rd1, 32'h99); chk("s5_first_rv1", a_rv1, 1); chk("s5_rd7", a_rd0, 0);
    we = 0; re0 = 1; rAddr0 = 4; re1 = 1; rAddr1 = 1; tick;
    chk("s5_rd4", a_rd0, 0); chk("s5_rd1", a_rd1, 0);
    idle_inputs; tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
